// File: rtl/term_pkg.sv
// Shared definitions for the terminal writer: controller states and character codes.
// Consumed by term_writer (optional backspace build: TERM_WRITER_BS_EN).
package term_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } term_state_e;

  localparam logic [7:0] CHAR_SPACE     = 8'h20;
  localparam logic [7:0] CHAR_LF        = 8'h0A;
  localparam logic [7:0] CHAR_CR        = 8'h0D;
  localparam logic [7:0] CHAR_BS        = 8'h08;
  localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;
  localparam logic [7:0] CHAR_PRINT_MAX = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHAR_PRINT_MIN) && (c <= CHAR_PRINT_MAX);
  endfunction

endpackage

// File: rtl/term_writer.sv
// Byte-stream to scrolling text buffer writer: clears VRAM, places characters, scrolls by moving top_row.
// Build option: define TERM_WRITER_BS_EN to make 0x08 erase the character left of the cursor.
module term_writer
  import term_pkg::*;
#(
  parameter int COLS = 64,
  parameter int ROWS = 16,
  localparam int AW = $clog2(COLS * ROWS),
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [AW-1:0] vram_addr,
  output logic [7:0]    vram_data,
  output logic          vram_we,
  output logic [RW-1:0] top_row,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LAST_BASE = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  term_state_e   state_q, state_d;
  logic [AW-1:0] init_addr_q, init_addr_d;
  logic [CW-1:0] clear_col_q, clear_col_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [RW-1:0] top_row_q, top_row_d;
  logic [CW-1:0] cursor_col_q, cursor_col_d;
  logic [RW-1:0] cursor_row_q, cursor_row_d;
  logic          vram_we_q, vram_we_d;
  logic [AW-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]    vram_data_q, vram_data_d;

  logic          handshake;
  logic          newline;
  logic [AW-1:0] cursor_addr;

  assign s_axis_tready = (state_q == ST_IDLE);
  assign handshake     = s_axis_tvalid && s_axis_tready;
  // row_base_q always points at the physical row under the cursor.
  assign cursor_addr   = row_base_q + AW'(cursor_col_q);

  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    clear_col_d  = clear_col_q;
    row_base_d   = row_base_q;
    top_row_d    = top_row_q;
    cursor_col_d = cursor_col_q;
    cursor_row_d = cursor_row_q;
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_data_d  = vram_data_q;
    newline      = 1'b0;

    case (state_q)
      ST_INIT: begin
        vram_we_d   = 1'b1;
        vram_addr_d = init_addr_q;
        vram_data_d = CHAR_SPACE;
        if (init_addr_q == LAST_ADDR) begin
          init_addr_d = '0;
          state_d     = ST_IDLE;
        end else begin
          init_addr_d = init_addr_q + AW'(1);
        end
      end

      ST_IDLE: begin
        if (handshake) begin
          if (is_printable(s_axis_tdata)) begin
            vram_we_d   = 1'b1;
            vram_addr_d = cursor_addr;
            vram_data_d = s_axis_tdata;
            if (cursor_col_q == LAST_COL) begin
              cursor_col_d = '0;
              newline      = 1'b1;
            end else begin
              cursor_col_d = cursor_col_q + CW'(1);
            end
          end else if (s_axis_tdata == CHAR_LF) begin
            cursor_col_d = '0;
            newline      = 1'b1;
          end else if (s_axis_tdata == CHAR_CR) begin
            cursor_col_d = '0;
`ifdef TERM_WRITER_BS_EN
          end else if ((s_axis_tdata == CHAR_BS) && (cursor_col_q != '0)) begin
            cursor_col_d = cursor_col_q - CW'(1);
            vram_we_d    = 1'b1;
            vram_addr_d  = row_base_q + AW'(cursor_col_q - CW'(1));
            vram_data_d  = CHAR_SPACE;
`endif
          end
        end
      end

      ST_CLEAR: begin
        vram_we_d   = 1'b1;
        vram_addr_d = row_base_q + AW'(clear_col_q);
        vram_data_d = CHAR_SPACE;
        if (clear_col_q == LAST_COL) begin
          clear_col_d = '0;
          state_d     = ST_IDLE;
        end else begin
          clear_col_d = clear_col_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Scrolling moves the cursor's physical row down one as well, so the base advances either way.
    if (newline) begin
      row_base_d = (row_base_q == LAST_BASE) ? '0 : row_base_q + COLS_A;
      if (cursor_row_q != LAST_ROW) begin
        cursor_row_d = cursor_row_q + RW'(1);
      end else begin
        top_row_d   = (top_row_q == LAST_ROW) ? '0 : top_row_q + RW'(1);
        clear_col_d = '0;
        state_d     = ST_CLEAR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_addr_q  <= '0;
      clear_col_q  <= '0;
      row_base_q   <= '0;
      top_row_q    <= '0;
      cursor_col_q <= '0;
      cursor_row_q <= '0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      clear_col_q  <= clear_col_d;
      row_base_q   <= row_base_d;
      top_row_q    <= top_row_d;
      cursor_col_q <= cursor_col_d;
      cursor_row_q <= cursor_row_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_data_q  <= vram_data_d;
    end
  end

  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_data  = vram_data_q;
  assign top_row    = top_row_q;
  assign cursor_col = cursor_col_q;
  assign cursor_row = cursor_row_q;

endmodule
